mc_control_fsm: RTL and testbench

- Control unit for the multicycle ARM-subset core.
- Sits directly upstream of the multicycle datapath and drives every datapath select and enable, plus memory write.
- Consumes Instr[31:12] and ALUFlags from the datapath; owns the NZCV flags register and condition evaluation.
- Moore main FSM with a condition-gated write layer.

---
 rtl/mc_ctrl_pkg.sv | 39 +++
 rtl/mc_condlogic.sv | 25 ++
 rtl/mc_control_fsm.sv | 124 ++++++++++++
 tb/tb_mc_control_fsm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state set, datapath select codes, condition and cmd constants for the multicycle control unit
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN, HALT
  } state_t;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
  localparam logic [1:0] RES_ALU = 2'b00, RES_ALUOUT = 2'b01, RES_RDATA = 2'b10;
  localparam logic [1:0] SRCA_REG = 2'b00, SRCA_PC = 2'b01;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic ADR_PC = 1'b0, ADR_ALU = 1'b1;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
                         CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
                         CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
                         CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE;
  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
                         CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;
  function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      CC_EQ: cond_ex = z;
      CC_NE: cond_ex = ~z;
      CC_CS: cond_ex = c;
      CC_CC: cond_ex = ~c;
      CC_MI: cond_ex = n;
      CC_PL: cond_ex = ~n;
      CC_VS: cond_ex = v;
      CC_VC: cond_ex = ~v;
      CC_HI: cond_ex = c & ~z;
      CC_LS: cond_ex = ~c | z;
      CC_GE: cond_ex = n == v;
      CC_LT: cond_ex = n != v;
      CC_GT: cond_ex = ~z & (n == v);
      CC_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/mc_condlogic.sv
// mc_condlogic: NZCV flags register, condition evaluation and the per-instruction cond_q latch
module mc_condlogic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_we,
  input  logic       nz_we,
  input  logic       cv_we,
  output logic       cond_q
);
  logic [3:0] nzcv;
  // flag writes are gated by the condition captured in DECODE, not by the live flags
  always_ff @(posedge clk)
    if (reset) begin
      nzcv   <= '0;
      cond_q <= 1'b0;
    end else begin
      if (cond_we) cond_q <= cond_ex(cond, nzcv);
      if (nz_we & cond_q) nzcv[3:2] <= alu_flags[3:2];
      if (cv_we & cond_q) nzcv[1:0] <= alu_flags[1:0];
    end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle ARM-subset control unit (Moore FSM + condition-gated strobes)
// Define MC_ILLEGAL_HALT_EN to make undefined ops enter a sticky HALT state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic        halted
);
  state_t     state;
  logic [3:0] cond, rd, cmd;
  logic [1:0] op, alu_cmd;
  logic [5:0] funct;
  logic       cond_q, dp_write, dp_cv, dp_flags, unused_rn;
  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^Instr[7:4];
  assign ImmSrc    = op;
  assign dp_write  = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_AND || cmd == CMD_ORR;
  assign dp_cv     = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP;
  assign dp_flags  = (state == EXECUTER || state == EXECUTEI) &&
                     ((funct[0] && dp_write) || cmd == CMD_CMP);
  assign alu_cmd   = (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
                     cmd == CMD_AND ? ALU_AND : cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
  mc_condlogic u_cond (
    .clk(clk),
    .reset(reset),
    .cond(cond),
    .alu_flags(ALUFlags),
    .cond_we(state == DECODE),
    .nz_we(dp_flags),
    .cv_we(dp_flags & dp_cv),
    .cond_q(cond_q)
  );
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else
      case (state)
        FETCH:              state <= DECODE;
        DECODE:             state <= op == 2'b00 ? (funct[5] ? EXECUTEI : EXECUTER) :
                                     op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH : UNKNOWN;
        EXECUTER, EXECUTEI: state <= ALUWB;
        MEMADR:             state <= funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:            state <= MEMWB;
`ifdef MC_ILLEGAL_HALT_EN
        UNKNOWN, HALT:      state <= HALT;
`endif
        default:            state <= FETCH;
      endcase
  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = ADR_PC;
    RegSrc     = 2'b00;
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALU;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
      end
      DECODE: begin
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        RegSrc  = {op == 2'b01, op == 2'b10};
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = state == EXECUTEI ? SRCB_IMM : SRCB_REG;
        ALUControl = alu_cmd;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = cond_q & dp_write & (rd != 4'hF);
        PCWrite   = cond_q & dp_write & (rd == 4'hF);
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
      end
      MEMREAD: AdrSrc = ADR_ALU;
      MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = cond_q;
      end
      MEMWRITE: begin
        AdrSrc   = ADR_ALU;
        MemWrite = cond_q;
      end
      BRANCH: begin
        ALUSrcB = SRCB_IMM;
        PCWrite = cond_q;
      end
      default: ;
    endcase
    if (reset) {PCWrite, MemWrite, RegWrite, IRWrite} = 4'b0000;
  end
`ifdef MC_ILLEGAL_HALT_EN
  assign halted = state == HALT;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized instruction stream checked each cycle against an instruction-level model
module tb_mc_control_fsm;
  logic clk = 1'b0, reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0] ALUFlags = '0;
  logic PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, halted;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .halted(halted)
  );
  always #5 clk = ~clk;
  localparam int S_F = 0, S_D = 1, S_XR = 2, S_XI = 3, S_WB = 4, S_MA = 5,
                 S_MR = 6, S_MB = 7, S_MW = 8, S_BR = 9, S_U = 10, S_H = 11;
  int checks = 0, errors = 0, cur_step = 0, cyc_idx = 0;
  logic chk_en = 1'b0, exp_halt = 1'b0, m_cond = 1'b0, fixf = 1'b0;
  logic [3:0] m_nzcv = '0, fixv = '0;
  logic [16:0] exp_vec = '0, act_vec;
  logic [16:0] obs [16];
  logic [19:0] r_ins;
  int r_at;
  logic [3:0] cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
  assign act_vec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d t=%0t got %h want %h", nm, cur_step, $time, act, exp);
    end
  endtask
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic [7:0] b;
    {n, z, cy, v} = f;
    b = {1'b1, !z && n == v, n == v, cy && !z, v, n, cy, z};
    if (c == 4'hF) return 1'b1;
    return c[0] ? !b[c[3:1]] : b[c[3:1]];
  endfunction
  function automatic logic [1:0] dp_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 2'b01;
      4'b0000:          return 2'b10;
      4'b1100:          return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction
  function automatic logic [16:0] model_out(input int step, input logic [19:0] ins,
                                            input logic cq, input logic rst);
    logic [1:0] op, rs, sa, sb, res, alu;
    logic [3:0] cmd;
    logic wr, pcw, mw, rw, irw, adr;
    op = ins[15:14];
    cmd = ins[12:9];
    wr = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
    {pcw, mw, rw, irw, adr} = 5'b0;
    {rs, sa, sb, res, alu} = 10'b0;
    case (step)
      S_F: begin irw = 1'b1; pcw = 1'b1; sa = 2'b01; sb = 2'b10; end
      S_D: begin sa = 2'b01; sb = 2'b10; rs = {op == 2'b01, op == 2'b10}; end
      S_XR, S_XI: begin sb = (step == S_XI) ? 2'b01 : 2'b00; alu = dp_alu(cmd); end
      S_WB: begin
        res = 2'b01;
        if (ins[3:0] == 4'hF) pcw = cq & wr; else rw = cq & wr;
      end
      S_MA: begin sb = 2'b01; alu = ins[11] ? 2'b00 : 2'b01; end
      S_MR: adr = 1'b1;
      S_MB: begin res = 2'b10; rw = cq; end
      S_MW: begin adr = 1'b1; mw = cq; end
      S_BR: begin sb = 2'b01; pcw = cq; end
      default: ;
    endcase
    if (rst) {pcw, mw, rw, irw} = 4'b0;
    return {pcw, mw, rw, irw, adr, rs, sa, sb, res, op, alu};
  endfunction
  task automatic run_instr(input logic [19:0] ins, input int rst_at_in);
    int st[$];
    int rst_at;
    logic [3:0] cmd;
    rst_at = rst_at_in;
    cmd = ins[12:9];
    st.push_back(S_F);
    st.push_back(S_D);
    case (ins[15:14])
      2'b00: begin st.push_back(ins[13] ? S_XI : S_XR); st.push_back(S_WB); end
      2'b01: begin
        st.push_back(S_MA);
        if (ins[8]) begin st.push_back(S_MR); st.push_back(S_MB); end
        else st.push_back(S_MW);
      end
      2'b10: st.push_back(S_BR);
      default: begin
        st.push_back(S_U);
`ifdef MC_ILLEGAL_HALT_EN
        repeat (3) st.push_back(S_H);
        if (rst_at < 0) rst_at = st.size() - 1;
`endif
      end
    endcase
    Instr = ins;
    for (int i = 0; i < st.size(); i++) begin
      if (rst_at >= 0 && i > rst_at) break;
      reset = (i == rst_at);
      ALUFlags = fixf ? fixv : 4'($urandom);
      cur_step = st[i];
      cyc_idx = i;
      exp_vec = model_out(st[i], ins, m_cond, reset);
      exp_halt = st[i] == S_H;
      chk_en = 1'b1;
      @(posedge clk);
      if (reset) begin
        m_nzcv = '0;
        m_cond = 1'b0;
      end else if (st[i] == S_D) m_cond = cond_holds(ins[19:16], m_nzcv);
      else if ((st[i] == S_XR || st[i] == S_XI) && m_cond &&
               ((ins[8] && cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100}) || cmd == 4'b1010)) begin
        m_nzcv[3:2] = ALUFlags[3:2];
        if (cmd inside {4'b0100, 4'b0010, 4'b1010}) m_nzcv[1:0] = ALUFlags[1:0];
      end
      #1;
    end
    reset = 1'b0;
  endtask
  always @(negedge clk)
    if (chk_en) begin
      obs[cyc_idx] = act_vec;
      check("outputs", 32'(act_vec), 32'(exp_vec));
      check("halted", 32'(halted), 32'(exp_halt));
      check("nzcv", 32'(dut.u_cond.nzcv), 32'(m_nzcv));
    end
  initial begin
    Instr = 20'hE2821;
    @(posedge clk);
    #1;
    cur_step = S_F;
    cyc_idx = 0;
    exp_vec = model_out(S_F, Instr, 1'b0, 1'b1);
    exp_halt = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(20'hE2821, -1);
    check("add_fetch_irw", 32'(obs[0][13]), 1);
    check("add_fetch_pcw", 32'(obs[0][16]), 1);
    check("add_fetch_srcb", 32'(obs[0][7:6]), 2);
    check("add_wb_regw", 32'(obs[3][14]), 1);
    check("add_wb_res", 32'(obs[3][5:4]), 1);
    run_instr(20'hE5921, -1);
    check("ldr_adr_srcb_alu", 32'({obs[2][7:6], obs[2][1:0]}), 32'h4);
    check("ldr_read_adr", 32'(obs[3][12]), 1);
    check("ldr_wb_res_regw", 32'({obs[4][5:4], obs[4][14]}), 32'h5);
    run_instr(20'hE5821, -1);
    check("str_memw_adr", 32'({obs[3][15], obs[3][12]}), 32'h3);
    check("str_no_regw", 32'({obs[0][14], obs[1][14], obs[2][14], obs[3][14]}), 0);
    fixf = 1'b1;
    fixv = 4'b0100;
    run_instr(20'hE1510, -1);
    fixf = 1'b0;
    check("cmp_no_regw", 32'(obs[3][14]), 0);
    check("cmp_nzcv", 32'(dut.u_cond.nzcv), 32'h4);
    run_instr(20'h0A000, -1);
    check("beq_taken", 32'(obs[2][16]), 1);
    run_instr(20'h1A000, -1);
    check("bne_not_taken", 32'(obs[2][16]), 0);
    run_instr(20'hE080F, -1);
    check("addpc_pcw_regw", 32'({obs[3][16], obs[3][14]}), 32'h2);
    run_instr(20'hE5821, 3);
    check("rst_memw", 32'(obs[3][15]), 0);
    run_instr(20'hE2821, -1);
    check("after_rst_fetch", 32'(obs[0][13]), 1);
    check("after_rst_nzcv", 32'(dut.u_cond.nzcv), 0);
    run_instr(20'hEC000, -1);
    check("undef_no_strobes", 32'(obs[2][16:13]), 0);
    for (int n = 0; n < 400; n++) begin
      r_ins = 20'($urandom);
      if ($urandom_range(2) == 0) r_ins[19:16] = 4'hE;
      if ($urandom_range(1) == 0) r_ins[12:9] = cmds[$urandom_range(4)];
      if ($urandom_range(3) == 0) r_ins[3:0] = 4'hF;
      r_at = ($urandom_range(19) == 0) ? int'($urandom_range(4)) : -1;
      run_instr(r_ins, r_at);
    end
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
